// File: rtl/cam_pkg.sv
// Shared types and default sizing for the 9T CAM sequencing controller.
// Holds the controller state enum and default array dimensions.
package cam_pkg;
  localparam int DEF_ROWS     = 16;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_ADDR_W   = 4;
  localparam int DEF_EVAL_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    PRECH,
    EVAL,
    WRITE,
    RESP
  } state_t;
endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder over the CAM match lines.
// In: match[ROWS]. Out: hit (any), multi (>1), addr (lowest set index).
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ROWS-1:0]   match,
  output logic              hit,
  output logic              multi,
  output logic [ADDR_W-1:0] addr
);
  // Scan high to low so the lowest set index wins.
  always_comb begin
    addr = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (match[i]) addr = ADDR_W'(i);
    end
  end

  assign hit   = |match;
  // Clearing the lowest set bit leaves something only if >1 bits were set.
  assign multi = |(match & (match - ROWS'(1)));
endmodule

// File: rtl/cam_search_ctrl.sv
// Write/search sequencer for a row-organised 9T CAM array.
// Ports: req_* request handshake, dl/dlb/wlwr/pre array drive,
// match array sense, rsp_* response handshake. All outputs registered.
module cam_search_ctrl
  import cam_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int EVAL_CYC = DEF_EVAL_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [WIDTH-1:0]  req_key,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [WIDTH-1:0]  dl,
  output logic [WIDTH-1:0]  dlb,
  output logic [ROWS-1:0]   wlwr,
  output logic              pre,
  input  logic [ROWS-1:0]   match,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_multi,
  output logic [ADDR_W-1:0] rsp_addr
);
  localparam int CW = $clog2(EVAL_CYC + 1);

  state_t            state, nstate;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  key_q, key_s;
  logic [ADDR_W-1:0] addr_q, addr_s;
  logic              acc, last_eval, last_wr;
  logic              e_hit, e_multi;
  logic [ADDR_W-1:0] e_addr;

  logic              n_ready, n_pre, n_rvalid;
  logic [WIDTH-1:0]  n_dl, n_dlb;
  logic [ROWS-1:0]   n_wlwr;

  assign acc       = (state == IDLE) && req_valid && req_ready;
  assign last_eval = (cnt == CW'(EVAL_CYC - 1));
  assign last_wr   = (cnt == CW'(1));
  // Outputs are registered from the next state, so on the accept edge
  // the request fields must bypass the latch.
  assign key_s     = (state == IDLE) ? req_key : key_q;
  assign addr_s    = (state == IDLE) ? req_addr : addr_q;

  cam_prio_enc #(
    .ROWS  (ROWS),
    .ADDR_W(ADDR_W)
  ) u_enc (
    .match(match),
    .hit  (e_hit),
    .multi(e_multi),
    .addr (e_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_q     <= '0;
      addr_q    <= '0;
      req_ready <= 1'b0;
      pre       <= 1'b0;
      dl        <= '0;
      dlb       <= '0;
      wlwr      <= '0;
      rsp_valid <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_multi <= 1'b0;
      rsp_addr  <= '0;
    end else begin
      state     <= nstate;
      cnt       <= (nstate != state) ? '0 : cnt + CW'(1);
      req_ready <= n_ready;
      pre       <= n_pre;
      dl        <= n_dl;
      dlb       <= n_dlb;
      wlwr      <= n_wlwr;
      rsp_valid <= n_rvalid;
      if (acc) begin
        key_q  <= req_key;
        addr_q <= req_addr;
      end
      if (state == EVAL && last_eval) begin
        rsp_hit   <= e_hit;
        rsp_multi <= e_multi;
        rsp_addr  <= e_addr;
      end
      if (state == WRITE && last_wr) begin
        rsp_hit   <= 1'b0;
        rsp_multi <= 1'b0;
        rsp_addr  <= addr_q;
      end
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (acc) nstate = req_wr ? WRITE : PRECH;
      PRECH: nstate = EVAL;
      EVAL:  if (last_eval) nstate = RESP;
      WRITE: if (last_wr) nstate = RESP;
      RESP:  if (rsp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    n_ready  = 1'b0;
    n_pre    = 1'b0;
    n_rvalid = 1'b0;
    n_dl     = '0;
    n_dlb    = '0;
    n_wlwr   = '0;
    unique case (nstate)
      IDLE:  n_ready = 1'b1;
      PRECH: n_pre = 1'b1;
      EVAL: begin
        n_dl  = key_s;
        n_dlb = ~key_s;
      end
      WRITE: begin
        n_dl  = key_s;
        n_dlb = ~key_s;
        // Out-of-range rows match no bit, dropping the write.
        for (int i = 0; i < ROWS; i++) begin
          n_wlwr[i] = (addr_s == ADDR_W'(i));
        end
      end
      RESP:  n_rvalid = 1'b1;
      default: n_ready = 1'b0;
    endcase
  end
endmodule
